// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS bit positions and RX FSM state encodings.
package uart_rx_port_pkg;

  localparam logic [11:0] OFF_DATA   = 12'd0;
  localparam logic [11:0] OFF_STATUS = 12'd1;
  localparam logic [11:0] OFF_CTRL   = 12'd2;

  localparam int ST_BIT_NOT_EMPTY = 0;
  localparam int ST_BIT_OVERRUN   = 1;
  localparam int ST_BIT_FRAME_ERR = 2;
  localparam int ST_BIT_FULL      = 3;
  localparam int ST_BIT_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [15:0] pack_status(input logic [3:0] count,
                                              input logic       full,
                                              input logic       frame_err,
                                              input logic       overrun,
                                              input logic       not_empty);
    logic [15:0] s;
    s = '0;
    s[ST_BIT_NOT_EMPTY]         = not_empty;
    s[ST_BIT_OVERRUN]           = overrun;
    s[ST_BIT_FRAME_ERR]         = frame_err;
    s[ST_BIT_FULL]              = full;
    s[ST_BIT_COUNT_LSB +: 4]    = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// Processor IO bus as seen by the UART receiver: address/strobe/data from the
// M stage, registered read data back to the W stage.
interface uart_rx_port_if;
  logic [11:0] IO_address;
  logic        IO_write;
  logic [15:0] IO_data_in;
  logic [15:0] IO_data_out;

  modport master (output IO_address, IO_write, IO_data_in, input IO_data_out);
  modport slave  (input IO_address, IO_write, IO_data_in, output IO_data_out);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; a pop in the same cycle as a push on a full FIFO frees
// the slot first so the push is accepted.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: synchroniser, baud down-counter, RX FSM,
// register decode with registered read mux, and a level interrupt.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synced 0
// RX_START | counting half a bit to re-check the start bit
// RX_DATA  | sampling 8 data bits, LSB first, at bit centres
// RX_STOP  | sampling stop bit; after a bad stop, waits for line high
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [11:0] BASE_ADDR    = 12'hF10,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  uart_rx_port_if.slave   bus,
  input  logic            uart_rx,
  output logic            rx_irq
);
  localparam int             BCW       = $clog2(CLKS_PER_BIT);
  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] BAUD_FULL = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1, r_sync2;
  rx_state_e       r_state, w_next_state;
  logic [BCW-1:0]  r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_stop_bad;
  logic            r_overrun, r_frame_err, r_irq_en, r_irq;
  logic [15:0]     r_data_out;

  logic            w_rx, w_baud_done, w_push, w_ferr_set;
  logic            w_sel_data, w_sel_status, w_sel_ctrl;
  logic            w_pop, w_ctrl_wr, w_clear;
  logic [7:0]      w_head;
  logic [CW-1:0]   w_count;
  logic            w_full, w_empty;
  logic [15:0]     w_rd_data;
  logic            w_unused_wdata;

  assign w_rx           = r_sync2;
  assign w_baud_done    = (r_cnt == '0);
  assign w_unused_wdata = ^bus.IO_data_in[15:2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= RX_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RX_IDLE:  if (!w_rx) w_next_state = RX_START;
      RX_START: if (w_baud_done) w_next_state = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_done && r_bit_idx == 3'd7) w_next_state = RX_STOP;
      RX_STOP:  if (w_baud_done && w_rx) w_next_state = RX_IDLE;
      default:  w_next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    if (r_state == RX_STOP && w_baud_done && !r_stop_bad) begin
      w_push     = w_rx;
      w_ferr_set = ~w_rx;
    end
  end

  // Counter holds at zero in STOP so a bad stop can wait for the line to rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_bad <= 1'b0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_cnt      <= BAUD_HALF;
          r_bit_idx  <= '0;
          r_stop_bad <= 1'b0;
        end
        RX_START: r_cnt <= w_baud_done ? BAUD_FULL : r_cnt - 1'b1;
        RX_DATA: begin
          if (w_baud_done) begin
            r_shift[r_bit_idx] <= w_rx;
            r_bit_idx          <= r_bit_idx + 1'b1;
            r_cnt              <= BAUD_FULL;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (!w_baud_done)  r_cnt <= r_cnt - 1'b1;
          else if (!w_rx)    r_stop_bad <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_shift),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_sel_data   = (bus.IO_address == BASE_ADDR + OFF_DATA);
  assign w_sel_status = (bus.IO_address == BASE_ADDR + OFF_STATUS);
  assign w_sel_ctrl   = (bus.IO_address == BASE_ADDR + OFF_CTRL);
  assign w_pop        = bus.IO_write & w_sel_data;
  assign w_ctrl_wr    = bus.IO_write & w_sel_ctrl;
  assign w_clear      = w_ctrl_wr & bus.IO_data_in[1];

  always_comb begin
    w_rd_data = 16'h0000;
    if (w_sel_data && !w_empty) w_rd_data = {8'h00, w_head};
    else if (w_sel_status)      w_rd_data = pack_status(4'(w_count), w_full, r_frame_err,
                                                        r_overrun, ~w_empty);
    else if (w_sel_ctrl)        w_rd_data = {15'h0000, r_irq_en};
  end

  // A new error in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_data_out  <= 16'h0000;
    end else begin
      r_overrun   <= (w_push & w_full & ~w_pop) | (r_overrun & ~w_clear);
      r_frame_err <= w_ferr_set | (r_frame_err & ~w_clear);
      if (w_ctrl_wr) r_irq_en <= bus.IO_data_in[0];
      r_irq       <= r_irq_en & (~w_empty | r_overrun | r_frame_err);
      r_data_out  <= w_rd_data;
    end
  end

  assign bus.IO_data_out = r_data_out;
  assign rx_irq          = r_irq;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: a table of bus/serial operations with
// expected read data, plus hand sequences for timing-sensitive corners.
module tb_uart_rx_port;
  localparam int          CPB       = 16;
  localparam logic [11:0] BASE      = 12'hF10;
  localparam logic [11:0] A_DATA    = BASE;
  localparam logic [11:0] A_STATUS  = BASE + 12'd1;
  localparam logic [11:0] A_CTRL    = BASE + 12'd2;
  localparam logic [11:0] A_IDLE    = 12'h000;
  // Line falls at negedge 0; 2 sync flops + IDLE edge, half bit, 9 full bits.
  localparam int          PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_TX = 2;

  typedef struct {
    int          op;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  logic uart_rx;
  logic rx_irq;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  uart_rx_port_if bus ();

  uart_rx_port #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .uart_rx (uart_rx),
    .rx_irq  (rx_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int op, input logic [11:0] a, input logic [15:0] wd,
                     input logic [15:0] ex, input string nm);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    bus.IO_address = a;
    bus.IO_write   = 1'b0;
    @(negedge clock);
    d = bus.IO_data_out;
    bus.IO_address = A_IDLE;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    bus.IO_address = a;
    bus.IO_write   = 1'b1;
    bus.IO_data_in = d;
    @(negedge clock);
    bus.IO_write   = 1'b0;
    bus.IO_address = A_IDLE;
    bus.IO_data_in = 16'h0000;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Line level for cycle c of a frame started at c=0 with a good stop bit.
  function automatic logic line_at(input int c, input logic [7:0] b);
    int k;
    k = c / CPB;
    if (k == 0)      return 1'b0;
    else if (k <= 8) return b[k-1];
    else             return 1'b1;
  endfunction

  initial begin
    logic [15:0] d;
    logic [7:0]  bval;
    int          irq_early;
    logic        seen_ne;

    reset_n        = 1'b0;
    uart_rx        = 1'b1;
    bus.IO_address = A_IDLE;
    bus.IO_write   = 1'b0;
    bus.IO_data_in = 16'h0000;

    add(OP_TX, A_IDLE,   16'h01A5, 16'h0000, "tx_a5");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0011, "single_status");
    add(OP_RD, A_DATA,   16'h0000, 16'h00A5, "single_data");
    add(OP_RD, A_CTRL,   16'h0000, 16'h0000, "ctrl_reset");
    add(OP_RD, 12'hF13,  16'h0000, 16'h0000, "unmapped_read");
    add(OP_WR, A_DATA,   16'h1234, 16'h0000, "pop_a5");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0000, "status_after_pop");
    add(OP_RD, A_DATA,   16'h0000, 16'h0000, "data_empty");
    add(OP_WR, A_DATA,   16'h0000, 16'h0000, "pop_empty");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0000, "status_pop_empty");
    for (int i = 1; i <= 5; i++) add(OP_TX, A_IDLE, 16'h0100 | 16'(i), 16'h0000, "tx_ovr");
    add(OP_RD, A_STATUS, 16'h0000, 16'h004B, "overrun_status");
    for (int i = 1; i <= 4; i++) begin
      add(OP_RD, A_DATA, 16'h0000, 16'(i), "overrun_data");
      add(OP_WR, A_DATA, 16'h0000, 16'h0000, "overrun_pop");
    end
    add(OP_RD, A_STATUS, 16'h0000, 16'h0002, "overrun_sticky");
    add(OP_WR, A_CTRL,   16'h0002, 16'h0000, "clear_ovr");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0000, "overrun_cleared");
    add(OP_TX, A_IDLE,   16'h003C, 16'h0000, "tx_bad_stop");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0004, "frame_err_status");
    add(OP_RD, A_DATA,   16'h0000, 16'h0000, "frame_err_no_data");
    add(OP_WR, A_CTRL,   16'h0002, 16'h0000, "clear_ferr");
    add(OP_RD, A_STATUS, 16'h0000, 16'h0000, "frame_err_cleared");
    add(OP_WR, A_CTRL,   16'h0001, 16'h0000, "irq_en_on");
    add(OP_RD, A_CTRL,   16'h0000, 16'h0001, "ctrl_readback");
    add(OP_WR, A_CTRL,   16'h0000, 16'h0000, "irq_en_off");
    add(OP_RD, A_CTRL,   16'h0000, 16'h0000, "ctrl_readback_off");

    repeat (3) @(negedge clock);
    check("reset_data_out", bus.IO_data_out, 16'h0000);
    check("reset_irq", {15'h0, rx_irq}, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_TX: send_frame(vecs[i].wdata[7:0], vecs[i].wdata[8]);
        OP_WR: wr(vecs[i].addr, vecs[i].wdata);
        default: begin
          rd(vecs[i].addr, d);
          check(vecs[i].name, d, vecs[i].exp);
        end
      endcase
    end

    // Short low pulse must be rejected at the start-bit re-check.
    uart_rx = 1'b0;
    repeat (4) @(negedge clock);
    uart_rx = 1'b1;
    repeat (40) @(negedge clock);
    rd(A_STATUS, d);
    check("glitch_status", d, 16'h0000);

    // Full FIFO, DATA pop on exactly the stop-bit push edge.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    rd(A_STATUS, d);
    check("sim_full_status", d, 16'h0049);
    bval = 8'h14;
    for (int c = 0; c < 10 * CPB + 8; c++) begin
      uart_rx        = line_at(c, bval);
      bus.IO_write   = (c == PUSH_EDGE - 1);
      bus.IO_address = (c == PUSH_EDGE - 1) ? A_DATA : A_IDLE;
      @(negedge clock);
    end
    bus.IO_write   = 1'b0;
    bus.IO_address = A_IDLE;
    rd(A_STATUS, d);
    check("sim_status", d, 16'h0049);
    for (int i = 1; i <= 4; i++) begin
      rd(A_DATA, d);
      check("sim_data", d, 16'h0010 + 16'(i));
      wr(A_DATA, 16'h0000);
    end
    rd(A_STATUS, d);
    check("sim_drained", d, 16'h0000);

    // Interrupt rises with the push and falls after the last pop.
    wr(A_CTRL, 16'h0001);
    check("irq_idle", {15'h0, rx_irq}, 16'h0000);
    bval      = 8'h7E;
    irq_early = 0;
    seen_ne   = 1'b0;
    for (int c = 0; c < 10 * CPB + 8; c++) begin
      uart_rx        = line_at(c, bval);
      bus.IO_address = A_STATUS;
      @(negedge clock);
      if (!seen_ne && bus.IO_data_out[0]) begin
        seen_ne = 1'b1;
        check("irq_with_push", {15'h0, rx_irq}, 16'h0001);
      end else if (!seen_ne && rx_irq) begin
        irq_early++;
      end
    end
    bus.IO_address = A_IDLE;
    check("irq_push_seen", {15'h0, seen_ne}, 16'h0001);
    check("irq_before_push", 16'(irq_early), 16'h0000);
    rd(A_DATA, d);
    check("irq_data", d, 16'h007E);
    wr(A_DATA, 16'h0000);
    check("irq_hold", {15'h0, rx_irq}, 16'h0001);
    @(negedge clock);
    check("irq_fall", {15'h0, rx_irq}, 16'h0000);

    // Reset during data bit 3 of a frame, then a clean byte.
    send_frame(8'h99, 1'b1);
    bus.IO_address = A_STATUS;
    @(negedge clock);
    check("pre_reset_status", bus.IO_data_out, 16'h0011);
    check("pre_reset_irq", {15'h0, rx_irq}, 16'h0001);
    bval = 8'h55;
    for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
      uart_rx = line_at(c, bval);
      @(negedge clock);
    end
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("reset_mid_data_out", bus.IO_data_out, 16'h0000);
    check("reset_mid_irq", {15'h0, rx_irq}, 16'h0000);
    bus.IO_address = A_IDLE;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    send_frame(8'hC3, 1'b1);
    rd(A_STATUS, d);
    check("post_reset_status", d, 16'h0011);
    rd(A_DATA, d);
    check("post_reset_data", d, 16'h00C3);
    check("post_reset_irq", {15'h0, rx_irq}, 16'h0000);
    wr(A_DATA, 16'h0000);
    rd(A_STATUS, d);
    check("post_reset_drained", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
